// File: rtl/imm_encoder.sv
// Immediate encoder: packs opcode, register/funct fields and a 32-bit
// immediate into an RV32 instruction word, flagging immediates that the
// selected format cannot represent. Two-stage valid/ready pipeline.
module imm_encoder #(
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode_in,
    input  logic [4:0]  rd_in,
    input  logic [4:0]  rs1_in,
    input  logic [4:0]  rs2_in,
    input  logic [2:0]  funct3_in,
    input  logic [6:0]  funct7_in,
    input  logic [31:0] imm_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr_out,
    output logic        err_out
);

    typedef enum logic [2:0] {
        FMT_U,
        FMT_J,
        FMT_I,
        FMT_B,
        FMT_S,
        FMT_CSR,
        FMT_R,
        FMT_BAD
    } fmt_e;

    // Stage 1 registers
    logic        s1_valid_q;
    logic [6:0]  s1_op_q;
    logic [4:0]  s1_rd_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [2:0]  s1_f3_q;
    logic [6:0]  s1_f7_q;
    logic [31:0] s1_imm_q;
    fmt_e        s1_fmt_q;
    logic        s1_err_q;

    // Stage 2 registers (drive the outputs)
    logic        s2_valid_q;
    logic [31:0] s2_instr_q;
    logic        s2_err_q;

    // Next-state values
    fmt_e        fmt_d;
    logic        err_d;
    logic [31:0] word_d;

    logic adv1;
    logic adv2;
    logic i_uniform;
    logic b_uniform;

    assign adv2      = !s2_valid_q || out_ready;
    assign adv1      = !s1_valid_q || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid_q;
    assign instr_out = s2_instr_q;
    assign err_out   = s2_err_q;

    // Sign-extension checks: upper bits all zero or all one
    assign i_uniform = (imm_in[31:11] == '0) || (imm_in[31:11] == '1);
    assign b_uniform = (imm_in[31:12] == '0) || (imm_in[31:12] == '1);

    // Classify the instruction format from opcode[6:2]
    always_comb begin
        fmt_d = FMT_BAD;
        case (opcode_in[6:2])
            5'b01101, 5'b00101:           fmt_d = FMT_U;
            5'b11011:                     fmt_d = FMT_J;
            5'b11001, 5'b00000, 5'b00100: fmt_d = FMT_I;
            5'b11000:                     fmt_d = FMT_B;
            5'b01000:                     fmt_d = FMT_S;
            5'b11100:                     fmt_d = FMT_CSR;
            5'b01100:                     fmt_d = FMT_R;
            default:                      fmt_d = FMT_BAD;
        endcase
    end

    // Range-check the immediate against the selected format
    always_comb begin
        err_d = 1'b1;
        case (fmt_d)
            FMT_U:        err_d = (imm_in[11:0] != '0);
            FMT_J:        err_d = imm_in[0] || (imm_in[31:20] != {12{imm_in[20]}});
            FMT_I, FMT_S: err_d = !i_uniform;
            FMT_B:        err_d = imm_in[0] || !b_uniform;
            FMT_CSR:      err_d = (imm_in[31:5] != '0);
            FMT_R:        err_d = 1'b0;
            default:      err_d = 1'b1;
        endcase
    end

    // Assemble the instruction word from the stage-1 fields
    always_comb begin
        word_d = NOP_WORD;
        case (s1_fmt_q)
            FMT_U:   word_d = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
            FMT_J:   word_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                               s1_imm_q[19:12], s1_rd_q, s1_op_q};
            FMT_I:   word_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
            FMT_B:   word_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q,
                               s1_f3_q, s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
            FMT_S:   word_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                               s1_imm_q[4:0], s1_op_q};
            FMT_CSR: word_d = {s1_f7_q, s1_rs2_q, s1_imm_q[4:0], s1_f3_q, s1_rd_q, s1_op_q};
            FMT_R:   word_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
            default: word_d = NOP_WORD;
        endcase
        if (s1_err_q) begin
            word_d = NOP_WORD;
        end
    end

    // Stage 1 occupancy
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            s1_valid_q <= 1'b0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
        end
    end

    // Stage 1 payload capture on accept
    always_ff @(posedge clk_in) begin
        if (adv1 && in_valid) begin
            s1_op_q  <= opcode_in;
            s1_rd_q  <= rd_in;
            s1_rs1_q <= rs1_in;
            s1_rs2_q <= rs2_in;
            s1_f3_q  <= funct3_in;
            s1_f7_q  <= funct7_in;
            s1_imm_q <= imm_in;
            s1_fmt_q <= fmt_d;
            s1_err_q <= err_d;
        end
    end

    // Stage 2: output register, held while the consumer stalls
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_q <= word_d;
                s2_err_q   <= s1_err_q;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder: directed vectors, boundary immediates,
// backpressure, reset flush and randomized round-trip through a decoder model.
module tb_imm_encoder;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode_in;
    logic [4:0]  rd_in;
    logic [4:0]  rs1_in;
    logic [4:0]  rs2_in;
    logic [2:0]  funct3_in;
    logic [6:0]  funct7_in;
    logic [31:0] imm_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic        err_out;

    always #5 clk_in = ~clk_in;

    imm_encoder #(.NOP_WORD(32'h00000013)) dut (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode_in (opcode_in),
        .rd_in     (rd_in),
        .rs1_in    (rs1_in),
        .rs2_in    (rs2_in),
        .funct3_in (funct3_in),
        .funct7_in (funct7_in),
        .imm_in    (imm_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_out (instr_out),
        .err_out   (err_out)
    );

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        err;
        logic        has_exact;
        logic [31:0] exact;
    } req_t;

    req_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   rnd_done;

    // Format categories: 0 U, 1 J, 2 I, 3 B, 4 S, 5 CSR, 6 R, 7 unknown
    logic [4:0] op_tab [11] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00000,
                                5'b00100, 5'b11000, 5'b01000, 5'b11100, 5'b01100,
                                5'b00011};

    logic [6:0]  b_op  [16] = '{7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011,
                                7'b0100011, 7'b0100011, 7'b1100011, 7'b1100011,
                                7'b1100011, 7'b1101111, 7'b1101111, 7'b1101111,
                                7'b1110011, 7'b1110011, 7'b0010111, 7'b0001011};
    logic [31:0] b_imm [16] = '{32'h000007FF, 32'hFFFFF800, 32'h00000800, 32'hFFFFF7FF,
                                32'hFFFFF800, 32'h00000800, 32'h00000FFE, 32'hFFFFF000,
                                32'h00001000, 32'h000FFFFE, 32'hFFF00000, 32'h00100000,
                                32'h0000001F, 32'h00000020, 32'hFFFFF000, 32'h00000000};

    function automatic int cat(input logic [4:0] f);
        case (f)
            5'b01101, 5'b00101:           return 0;
            5'b11011:                     return 1;
            5'b11001, 5'b00000, 5'b00100: return 2;
            5'b11000:                     return 3;
            5'b01000:                     return 4;
            5'b11100:                     return 5;
            5'b01100:                     return 6;
            default:                      return 7;
        endcase
    endfunction

    // Representability expressed as numeric ranges and alignment
    function automatic logic model_err(input logic [6:0] op, input logic [31:0] imm);
        int s;
        s = int'(signed'(imm));
        case (cat(op[6:2]))
            0: return (imm % 4096) != 0;
            1: return (s % 2 != 0) || s < -(1 << 20) || s > (1 << 20) - 1;
            2, 4: return s < -2048 || s > 2047;
            3: return (s % 2 != 0) || s < -4096 || s > 4095;
            5: return imm > 31;
            6: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Core-style immediate decoder
    function automatic logic [31:0] dec_imm(input logic [31:0] w);
        case (cat(w[6:2]))
            0: return {w[31:12], 12'b0};
            1: return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            2: return {{20{w[31]}}, w[31:20]};
            3: return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            4: return {{20{w[31]}}, w[31:25], w[11:7]};
            5: return {27'b0, w[19:15]};
            default: return 32'b0;
        endcase
    endfunction

    function automatic logic fields_ok(input logic [31:0] w, input req_t e);
        logic ok;
        ok = (w[6:0] == e.op);
        case (cat(e.op[6:2]))
            0, 1: ok = ok && (w[11:7] == e.rd);
            2:    ok = ok && (w[11:7] == e.rd) && (w[19:15] == e.rs1) && (w[14:12] == e.f3);
            3, 4: ok = ok && (w[24:20] == e.rs2) && (w[19:15] == e.rs1) && (w[14:12] == e.f3);
            5:    ok = ok && (w[11:7] == e.rd) && (w[14:12] == e.f3) &&
                       (w[24:20] == e.rs2) && (w[31:25] == e.f7);
            6:    ok = ok && (w[11:7] == e.rd) && (w[19:15] == e.rs1) && (w[14:12] == e.f3) &&
                       (w[24:20] == e.rs2) && (w[31:25] == e.f7);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic req_t make_req(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] imm);
        req_t r;
        r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.f3 = f3; r.f7 = f7; r.imm = imm;
        r.err = model_err(op, imm);
        r.has_exact = 1'b0;
        r.exact = '0;
        return r;
    endfunction

    function automatic req_t rnd_req();
        logic [4:0]  f5;
        logic [1:0]  lo;
        logic [31:0] imm;
        logic [31:0] r;
        int          v;
        f5 = op_tab[$urandom_range(0, 10)];
        lo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        r  = $urandom();
        case (cat(f5))
            0: imm = r & 32'hFFFFF000;
            1: begin v = int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19); imm = 32'(v * 2); end
            2, 4: begin v = int'($urandom_range(0, 4095)) - 2048; imm = 32'(v); end
            3: begin v = int'($urandom_range(0, 4095)) - 2048; imm = 32'(v * 2); end
            5: imm = 32'($urandom_range(0, 31));
            default: imm = r;
        endcase
        if ($urandom_range(0, 9) < 3) imm = $urandom();
        return make_req({f5, lo}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                        5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                        7'($urandom_range(0, 127)), imm);
    endfunction

    task automatic drive(input req_t r);
        opcode_in = r.op; rd_in = r.rd; rs1_in = r.rs1; rs2_in = r.rs2;
        funct3_in = r.f3; funct7_in = r.f7; imm_in = r.imm;
        in_valid  = 1'b1;
    endtask

    // Present one request and wait (bounded) for the handshake
    task automatic send(input req_t r);
        bit acc;
        bit done;
        done = 1'b0;
        drive(r);
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk_in);
            acc = in_ready;
            @(posedge clk_in);
            if (acc) begin
                q.push_back(r);
                done = 1'b1;
            end
        end
        tests++;
        assert (done === 1'b1) else begin
            fails++; $error("FAIL send_timeout obs=%0b exp=1", done);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic check_word(input req_t e);
        tests++;
        assert (err_out === e.err) else begin
            fails++; $error("FAIL err op=%b imm=%h obs=%0b exp=%0b", e.op, e.imm, err_out, e.err);
        end
        if (e.err) begin
            tests++;
            assert (instr_out === NOP) else begin
                fails++; $error("FAIL nop_word obs=%h exp=%h", instr_out, NOP);
            end
        end else begin
            if (e.has_exact) begin
                tests++;
                assert (instr_out === e.exact) else begin
                    fails++; $error("FAIL exact_word obs=%h exp=%h", instr_out, e.exact);
                end
            end
            if (cat(e.op[6:2]) != 6) begin
                tests++;
                assert (dec_imm(instr_out) === e.imm) else begin
                    fails++; $error("FAIL roundtrip_imm word=%h obs=%h exp=%h",
                                    instr_out, dec_imm(instr_out), e.imm);
                end
            end
            tests++;
            assert (fields_ok(instr_out, e) === 1'b1) else begin
                fails++; $error("FAIL fields op=%b word=%h obs=0 exp=1", e.op, instr_out);
            end
        end
    endtask

    // Output monitor: scoreboard pop on handshake, stability under stall
    logic        hold_pending = 1'b0;
    logic [32:0] held;
    req_t        exp_e;
    always @(negedge clk_in) begin
        if (reset_in) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending && out_valid) begin
                tests++;
                assert ({instr_out, err_out} === held) else begin
                    fails++; $error("FAIL hold_stable obs=%h exp=%h", {instr_out, err_out}, held);
                end
            end
            hold_pending = out_valid && !out_ready;
            held = {instr_out, err_out};
            if (out_valid && out_ready) begin
                tests++;
                assert (q.size() > 0) else begin
                    fails++; $error("FAIL unexpected_word obs=%h exp=none", instr_out);
                end
                if (q.size() > 0) begin
                    exp_e = q.pop_front();
                    check_word(exp_e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t r;
        reset_in = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode_in = '0; rd_in = '0; rs1_in = '0; rs2_in = '0;
        funct3_in = '0; funct7_in = '0; imm_in = '0;
        repeat (3) @(posedge clk_in);
        #1 reset_in = 1'b0;

        // Reset state
        @(negedge clk_in);
        tests++; assert (out_valid === 1'b0) else begin fails++; $error("FAIL rst_out_valid obs=%0b exp=0", out_valid); end
        tests++; assert (in_ready === 1'b1) else begin fails++; $error("FAIL rst_in_ready obs=%0b exp=1", in_ready); end
        tests++; assert (instr_out === 32'h0) else begin fails++; $error("FAIL rst_instr obs=%h exp=0", instr_out); end
        tests++; assert (err_out === 1'b0) else begin fails++; $error("FAIL rst_err obs=%0b exp=0", err_out); end

        // ADDI x1,x2,-1 with latency check
        @(posedge clk_in); #1;
        r = make_req(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        r.has_exact = 1'b1; r.exact = 32'hFFF10093;
        drive(r);
        @(posedge clk_in);
        q.push_back(r);
        #1 in_valid = 1'b0;
        @(negedge clk_in);
        tests++; assert (out_valid === 1'b0) else begin fails++; $error("FAIL latency_c1 obs=%0b exp=0", out_valid); end
        @(negedge clk_in);
        tests++; assert (out_valid === 1'b1) else begin fails++; $error("FAIL latency_c2 obs=%0b exp=1", out_valid); end
        @(posedge clk_in); #1;

        // Directed vectors
        r = make_req(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
        r.has_exact = 1'b1; r.exact = 32'hFE208EE3;
        send(r);
        send(make_req(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3));
        r = make_req(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        r.has_exact = 1'b1; r.exact = 32'h001000EF;
        send(r);
        send(make_req(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001));

        // Boundary immediates
        for (int i = 0; i < 16; i++) begin
            send(make_req(b_op[i], 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                          7'($urandom_range(0, 127)), b_imm[i]));
        end

        // Backpressure: five back-to-back, consumer stalls three cycles
        fork
            begin
                for (int i = 0; i < 5; i++) send(rnd_req());
            end
            begin
                repeat (2) @(posedge clk_in);
                #1 out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk_in);
                    tests++;
                    assert (in_ready === 1'b0) else begin
                        fails++; $error("FAIL bp_in_ready obs=%0b exp=0", in_ready);
                    end
                    @(posedge clk_in);
                end
                #1 out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk_in);

        // Reset with both stages full
        #1 out_ready = 1'b0;
        send(rnd_req());
        send(rnd_req());
        reset_in = 1'b1;
        @(posedge clk_in);
        q.delete();
        #1 reset_in = 1'b0; out_ready = 1'b1;
        @(negedge clk_in);
        tests++; assert (out_valid === 1'b0) else begin fails++; $error("FAIL flush_out_valid obs=%0b exp=0", out_valid); end
        tests++; assert (in_ready === 1'b1) else begin fails++; $error("FAIL flush_in_ready obs=%0b exp=1", in_ready); end
        repeat (5) @(posedge clk_in);
        #1;

        // Randomized traffic with random consumer stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk_in); #1;
                    end
                    send(rnd_req());
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk_in);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        // Drain
        for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk_in);
        repeat (2) @(posedge clk_in);
        tests++;
        assert (q.size() === 0) else begin
            fails++; $error("FAIL drain_pending obs=%0d exp=0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
